// File: rtl/vx_tensor_tile_unit_if.sv
// Bus bundle for the tensor tile unit: job control, load stream and store stream.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge where
// valid and ready are both 1. The producer holds valid and its data stable until
// that edge; ready may depend on state but never on valid. in_ready is 1 only
// while loading; out_valid is 1 only while storing.
interface vx_tensor_tile_unit_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_c;
    logic              out_last;
    logic              done;
    logic [1:0]        state_dbg;   // FSM state: 0 IDLE, 1 LOAD, 2 EXEC, 3 STORE

    modport master (
        output start, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_c, out_last, done, state_dbg
    );

    modport slave (
        input  start, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_c, out_last, done, state_dbg
    );
endinterface

// File: rtl/vx_tensor_tile_unit.sv
// Square tile matrix multiply C = A x B. A and B are streamed in row-major,
// multiplied with one MAC per cycle (k innermost), and C is streamed out
// row-major. All arithmetic is unsigned and wraps modulo 2^DATA_W.
module vx_tensor_tile_unit #(
    parameter int TILE_N = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,   // asynchronous, active low
    vx_tensor_tile_unit_if.slave  bus
);
    localparam int NN    = TILE_N * TILE_N;
    localparam int IDX_W = $clog2(NN);
    localparam int CW    = $clog2(TILE_N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(TILE_N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_STORE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW-1:0]     i_q, i_d;
    logic [CW-1:0]     j_q, j_d;
    logic [CW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] a_q [NN];
    logic [DATA_W-1:0] b_q [NN];
    logic [DATA_W-1:0] c_q [NN];

    logic              load_we;
    logic              c_we;
    logic [IDX_W-1:0]  a_sel, b_sel, c_sel;
    logic [DATA_W-1:0] mac_sum;

    // Operand/result addressing for the current (i, j, k) step
    always_comb begin
        a_sel = IDX_W'(int'(i_q) * TILE_N + int'(k_q));
        b_sel = IDX_W'(int'(k_q) * TILE_N + int'(j_q));
        c_sel = IDX_W'(int'(i_q) * TILE_N + int'(j_q));
        // k == 0 starts a fresh dot product; the product is truncated to DATA_W
        mac_sum = ((k_q == '0) ? '0 : acc_q) + a_q[a_sel] * b_q[b_sel];
    end

    // Next-state, counter and write-enable logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        load_we = 1'b0;
        c_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_EXEC;
                        idx_d   = '0;
                        i_d     = '0;
                        j_d     = '0;
                        k_d     = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                acc_d = mac_sum;
                if (k_q == LAST_CNT) begin
                    c_we = 1'b1;
                    k_d  = '0;
                    if (j_q == LAST_CNT) begin
                        j_d = '0;
                        if (i_q == LAST_CNT) begin
                            i_d     = '0;
                            state_d = S_STORE;
                            idx_d   = '0;
                        end else begin
                            i_d = i_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_STORE: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    // Tile storage: A/B captured on load beats, C written at the end of each dot product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            if (load_we) begin
                a_q[idx_q] <= bus.in_a;
                b_q[idx_q] <= bus.in_b;
            end
            if (c_we) begin
                c_q[c_sel] <= mac_sum;
            end
        end
    end

    // Outputs are pure functions of registered state, so reset zeroes them at once
    always_comb begin
        bus.busy      = (state_q != S_IDLE);
        bus.in_ready  = (state_q == S_LOAD);
        bus.out_valid = (state_q == S_STORE);
        bus.out_c     = (state_q == S_STORE) ? c_q[idx_q] : '0;
        bus.out_last  = (state_q == S_STORE) && (idx_q == LAST_IDX);
        bus.done      = done_q;
        bus.state_dbg = state_q;
    end
endmodule
